// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, functs,
// datapath select codes, FSM state codes and instruction classes.
package mc_ctrl_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;

    localparam logic [1:0] EXT_SIGN = 2'd0;
    localparam logic [1:0] EXT_ZERO = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_LUI = 4'd6;

    localparam logic [1:0] NPC_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;

    localparam logic [1:0] GPRSel_RD = 2'd0;
    localparam logic [1:0] GPRSel_RT = 2'd1;

    localparam logic [1:0] WDSel_FromALU = 2'd0;
    localparam logic [1:0] WDSel_FromMEM = 2'd1;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_IMM     = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_e;

    // True for opcodes whose second ALU operand is the extended immediate
    function automatic logic uses_imm(input logic [5:0] op);
        return op inside {OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW};
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Bundle between the controller and the datapath: IR fields and status
// flowing in, enables and mux selects flowing out.
interface mc_ctrl_fsm_if;

    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_rdy;

    logic       PCWr;
    logic       IRWr;
    logic       RFWr;
    logic       DMWr;
    logic       DMRd;
    logic [1:0] EXTOp;
    logic [3:0] ALUOp;
    logic       ALUSrc;
    logic [1:0] NPCOp;
    logic [1:0] GPRSel;
    logic [1:0] WDSel;
    logic       illegal;
    logic       mem_abort;

    modport master (
        input  Op, Funct, Zero, mem_rdy,
        output PCWr, IRWr, RFWr, DMWr, DMRd, EXTOp, ALUOp, ALUSrc,
               NPCOp, GPRSel, WDSel, illegal, mem_abort
    );

    modport slave (
        output Op, Funct, Zero, mem_rdy,
        input  PCWr, IRWr, RFWr, DMWr, DMRd, EXTOp, ALUOp, ALUSrc,
               NPCOp, GPRSel, WDSel, illegal, mem_abort
    );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Pure combinational instruction decoder: classifies Op/Funct and derives
// the selects that stay fixed for the life of one instruction.
module mc_ctrl_decode
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    output instr_class_e cls,
    output logic [1:0]   ext_op,
    output logic [3:0]   alu_op,
    output logic         alu_src
);

    // Anything not recognised falls through as illegal with neutral selects
    always_comb begin
        cls     = CLS_ILLEGAL;
        ext_op  = EXT_SIGN;
        alu_op  = ALU_NOP;
        alu_src = uses_imm(op);
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADDU: begin cls = CLS_RTYPE; alu_op = ALU_ADD; end
                    FUNCT_SUBU: begin cls = CLS_RTYPE; alu_op = ALU_SUB; end
                    FUNCT_AND:  begin cls = CLS_RTYPE; alu_op = ALU_AND; end
                    FUNCT_OR:   begin cls = CLS_RTYPE; alu_op = ALU_OR;  end
                    FUNCT_SLT:  begin cls = CLS_RTYPE; alu_op = ALU_SLT; end
                    default:    ;
                endcase
            end
            OP_ADDIU: begin cls = CLS_IMM;    alu_op = ALU_ADD; end
            OP_ORI:   begin cls = CLS_IMM;    alu_op = ALU_OR;  ext_op = EXT_ZERO; end
            OP_LUI:   begin cls = CLS_IMM;    alu_op = ALU_LUI; ext_op = EXT_LUI;  end
            OP_LW:    begin cls = CLS_LOAD;   alu_op = ALU_ADD; end
            OP_SW:    begin cls = CLS_STORE;  alu_op = ALU_ADD; end
            OP_BEQ:   begin cls = CLS_BRANCH; alu_op = ALU_SUB; end
            OP_J:     begin cls = CLS_JUMP; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main controller: walks each instruction through
// IF/ID/EXE/MEM/WB and drives the datapath enables and selects.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 16
)
(
    input logic           clk,
    input logic           rst,
    mc_ctrl_fsm_if.master bus
);

    localparam int CNT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_WAIT_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    instr_class_e cls;
    logic [1:0]   dec_ext;
    logic [3:0]   dec_alu;
    logic         dec_src;

    logic       pc_wr, ir_wr, rf_wr, dm_wr, dm_rd, illegal, mem_abort;
    logic [1:0] npc_op, gpr_sel, wd_sel, ext_op;
    logic [3:0] alu_op;
    logic       alu_src;

    mc_ctrl_decode u_decode (
        .op      (bus.Op),
        .funct   (bus.Funct),
        .cls     (cls),
        .ext_op  (dec_ext),
        .alu_op  (dec_alu),
        .alu_src (dec_src)
    );

    // State and MEM wait counter; reset drops any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IF;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next state and all outputs; the abort cycle is the MEM cycle after
    // MEM_WAIT_MAX consecutive not-ready cycles, and a late ready still wins
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        rf_wr      = 1'b0;
        dm_wr      = 1'b0;
        dm_rd      = 1'b0;
        illegal    = 1'b0;
        mem_abort  = 1'b0;
        npc_op     = NPC_PLUS4;
        gpr_sel    = GPRSel_RD;
        wd_sel     = WDSel_FromALU;
        ext_op     = EXT_SIGN;
        alu_op     = ALU_NOP;
        alu_src    = 1'b0;

        if (state_q != S_IF) begin
            ext_op  = dec_ext;
            alu_op  = dec_alu;
            alu_src = dec_src;
        end

        case (state_q)
            S_IF: begin
                ir_wr   = 1'b1;
                pc_wr   = 1'b1;
                npc_op  = NPC_PLUS4;
                state_d = S_ID;
            end
            S_ID: begin
                case (cls)
                    CLS_JUMP: begin
                        pc_wr   = 1'b1;
                        npc_op  = NPC_JUMP;
                        state_d = S_IF;
                    end
                    CLS_ILLEGAL: begin
                        illegal = 1'b1;
                        state_d = S_IF;
                    end
                    default: state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                case (cls)
                    CLS_LOAD, CLS_STORE: state_d = S_MEM;
                    CLS_RTYPE, CLS_IMM:  state_d = S_WB;
                    CLS_BRANCH: begin
                        pc_wr   = bus.Zero;
                        npc_op  = NPC_BRANCH;
                        state_d = S_IF;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_MEM: begin
                dm_rd = (cls == CLS_LOAD);
                dm_wr = (cls == CLS_STORE);
                if (bus.mem_rdy) begin
                    state_d = (cls == CLS_LOAD) ? S_WB : S_IF;
                end else if ((MEM_WAIT_MAX != 0) && (wait_cnt_q == WAIT_LIMIT)) begin
                    mem_abort = 1'b1;
                    dm_rd     = 1'b0;
                    dm_wr     = 1'b0;
                    state_d   = S_IF;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                rf_wr   = 1'b1;
                gpr_sel = (cls == CLS_RTYPE) ? GPRSel_RD : GPRSel_RT;
                wd_sel  = (cls == CLS_LOAD) ? WDSel_FromMEM : WDSel_FromALU;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase

        if (rst) begin
            pc_wr     = 1'b0;
            ir_wr     = 1'b0;
            rf_wr     = 1'b0;
            dm_wr     = 1'b0;
            dm_rd     = 1'b0;
            illegal   = 1'b0;
            mem_abort = 1'b0;
            npc_op    = NPC_PLUS4;
            gpr_sel   = GPRSel_RD;
            wd_sel    = WDSel_FromALU;
            ext_op    = EXT_SIGN;
            alu_op    = ALU_NOP;
            alu_src   = 1'b0;
        end
    end

    assign bus.PCWr      = pc_wr;
    assign bus.IRWr      = ir_wr;
    assign bus.RFWr      = rf_wr;
    assign bus.DMWr      = dm_wr;
    assign bus.DMRd      = dm_rd;
    assign bus.EXTOp     = ext_op;
    assign bus.ALUOp     = alu_op;
    assign bus.ALUSrc    = alu_src;
    assign bus.NPCOp     = npc_op;
    assign bus.GPRSel    = gpr_sel;
    assign bus.WDSel     = wd_sel;
    assign bus.illegal   = illegal;
    assign bus.mem_abort = mem_abort;

endmodule
